// File: rtl/control_sequencer.sv
// control_sequencer: decodes sequence-generator phase strobes and the fetched instruction into datapath strobes.
// Ports: clock, input_reset_n (async, active-low); input_fetch/decode/execute/increment one-hot phases;
//   input_instruction [7:5] opcode [4:0] operand; input_zero_flag from the ALU;
//   output_hold stalls the generator; output_memory_read/ir_load fetch strobes; output_alu_op;
//   output_reg_write/memory_write/pc_load/pc_increment datapath strobes; output_operand registered IR[4:0];
//   output_halted; output_phase_error sticky protocol-violation flag.
// Build option: define PHASE_CHECK_EN to include the phase-order checker; otherwise output_phase_error is tied to 0.
module control_sequencer #(
  parameter int EXEC_MAX = 2
) (
  input  logic       clock,
  input  logic       input_reset_n,
  input  logic       input_fetch,
  input  logic       input_decode,
  input  logic       input_execute,
  input  logic       input_increment,
  input  logic [7:0] input_instruction,
  input  logic       input_zero_flag,
  output logic       output_hold,
  output logic       output_memory_read,
  output logic       output_ir_load,
  output logic [2:0] output_alu_op,
  output logic       output_reg_write,
  output logic       output_memory_write,
  output logic       output_pc_load,
  output logic       output_pc_increment,
  output logic [4:0] output_operand,
  output logic       output_halted,
  output logic       output_phase_error
);
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;
  localparam logic [2:0] EMAX     = 3'(EXEC_MAX);
  logic [7:0] ir;
  logic [1:0] exec_count;
  logic       jump_taken, halted, armed;
  logic [2:0] op, len;
  logic       run, fe, de, ex, inc, last;
  assign op   = ir[7:5];
  assign len  = (op == OP_LOAD || op == OP_STORE) ? ((EMAX < 3'd2) ? EMAX : 3'd2) : 3'd1;
  assign last = exec_count == 2'd0;
  // armed keeps decode/execute/increment inert after reset until a fresh fetch arrives
  assign run  = input_reset_n & ~halted;
  assign fe   = input_fetch & run;
  assign de   = input_decode & run & armed;
  assign ex   = input_execute & run & armed;
  assign inc  = input_increment & run & armed;
  assign output_hold         = input_reset_n & (halted | (ex & ~last));
  assign output_memory_read  = fe;
  assign output_ir_load      = fe;
  assign output_alu_op       = !ex ? 3'b000 : op == OP_ADD ? 3'b001 : op == OP_SUB ? 3'b010 : 3'b000;
  assign output_reg_write    = ex & ((op == OP_LOAD & last) | op == OP_ADD | op == OP_SUB);
  assign output_memory_write = ex & op == OP_STORE & last;
  assign output_pc_load      = ex & (op == OP_JMP | (op == OP_JZ & input_zero_flag));
  assign output_pc_increment = inc & ~jump_taken;
  assign output_operand      = ir[4:0];
  assign output_halted       = halted;
  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      ir         <= 8'h00;
      exec_count <= 2'd0;
      jump_taken <= 1'b0;
      halted     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      if (fe) begin
        ir    <= input_instruction;
        armed <= 1'b1;
      end
      if (de) exec_count <= 2'(len - 3'd1);
      if (ex && !last) exec_count <= exec_count - 2'd1;
      if (ex && output_pc_load) jump_taken <= 1'b1;
      if (ex && last && op == OP_HALT) halted <= 1'b1;
      if (inc) jump_taken <= 1'b0;
    end
  end
`ifdef PHASE_CHECK_EN
  typedef enum logic [2:0] {PH_NONE, PH_FETCH, PH_DECODE, PH_EXEC, PH_INC} phase_t;
  phase_t     ph_q, ph_d;
  logic       err_q, err_d;
  logic [3:0] phases;
  assign phases = {input_fetch, input_decode, input_execute, input_increment};
  // until the first fetch after reset, no phase history exists, so only a fetch is tracked
  always_comb begin
    ph_d  = input_fetch ? PH_FETCH : input_decode ? PH_DECODE : input_execute ? PH_EXEC :
            input_increment ? PH_INC : ph_q;
    err_d = err_q;
    if ((phases & (phases - 4'd1)) != 4'd0) err_d = 1'b1;
    else if (ph_q == PH_NONE) ph_d = input_fetch ? PH_FETCH : PH_NONE;
    else if ((input_fetch && ph_q != PH_INC) || (input_decode && ph_q != PH_FETCH) ||
             (input_execute && ph_q != PH_DECODE && ph_q != PH_EXEC) ||
             (input_increment && ph_q != PH_EXEC)) err_d = 1'b1;
  end
  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      ph_q  <= PH_NONE;
      err_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      err_q <= err_d;
    end
  end
  assign output_phase_error = err_q;
`else
  assign output_phase_error = 1'b0;
`endif
endmodule
